// File: rtl/synthy_boy.sv
`timescale 1ns / 1ps
// synthy_boy: single-voice digital tone generator.
//
// A 24-bit phase accumulator drives one of four waveform shapers (square, sawtooth,
// triangle, quarter-wave sine ROM). The selected shape is registered, scaled by an
// unsigned 16-bit amplitude and emitted as a registered signed 16-bit sample every clock.
//
// Ports:
//   i_clk50mhz  in   1  system clock, rising edge
//   i_rst       in   1  synchronous active-high reset
//   i_amp       in  16  unsigned amplitude (0x0000 silence, 0xFFFF full scale)
//   i_mux_sel   in   2  00 square, 01 sawtooth, 10 triangle, 11 sine
//   o_data      out 16  signed two's-complement sample, registered
module synthy_boy #(
  parameter int unsigned PHASE_INC = 336
) (
  input  logic               i_clk50mhz,
  input  logic               i_rst,
  input  logic [15:0]        i_amp,
  input  logic [1:0]         i_mux_sel,
  output logic signed [15:0] o_data
);

  // pi * 2^30, the fixed-point base for the elaboration-time sine table.
  localparam longint PiFx = 64'sd3373259426;

  // lut[i] = round(32767 * sin(pi/2 * (i + 0.5) / 256)), evaluated at elaboration
  // with a Q30 Taylor series so the ROM contents come from the formula, not a pasted table.
  function automatic logic [14:0] sine_lut_val(input int unsigned idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    x    = (PiFx * longint'(2 * idx + 1) + 64'sd512) >>> 10;
    x2   = (x * x + (64'sd1 <<< 29)) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -(term * x2) / (longint'((2 * n) * (2 * n + 1)) <<< 30);
      sum  = sum + term;
    end
    scaled = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    return scaled[14:0];
  endfunction

  logic [14:0] lut [256];

  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [14:0] LutVal = sine_lut_val(g);
    assign lut[g] = LutVal;
  end

  logic [23:0]        acc_q;
  logic [23:0]        acc_d;
  logic signed [15:0] wave_q;
  logic signed [15:0] wave_d;
  logic signed [15:0] data_d;

  logic [15:0]        ph;
  logic [14:0]        tri_t;
  logic [1:0]         quad;
  logic [7:0]         sin_idx;
  logic [15:0]        sin_mag;

  logic signed [32:0] wave_ext;
  logic signed [32:0] amp_ext;
  logic signed [32:0] prod;

  assign ph     = acc_q[23:8];
  assign acc_d  = acc_q + PHASE_INC[23:0];

  always_comb begin
    tri_t   = ph[15] ? ~ph[14:0] : ph[14:0];
    quad    = ph[15:14];
    // Odd quadrants walk the quarter-wave table backwards.
    sin_idx = quad[0] ? ~ph[13:6] : ph[13:6];
    sin_mag = {1'b0, lut[sin_idx]};
    wave_d  = '0;
    unique case (i_mux_sel)
      2'b00:   wave_d = ph[15] ? -16'sd32768 : 16'sd32767;
      2'b01:   wave_d = $signed(ph ^ 16'h8000);
      2'b10:   wave_d = $signed({tri_t, 1'b0} ^ 16'h8000);
      2'b11:   wave_d = quad[1] ? -$signed(sin_mag) : $signed(sin_mag);
      default: wave_d = '0;
    endcase
  end

  // Amplitude is zero-extended so 0xFFFF stays a positive multiplier; the product can
  // never exceed 16 signed bits after the >>16.
  always_comb begin
    wave_ext = {{17{wave_q[15]}}, wave_q};
    amp_ext  = {17'b0, i_amp};
    prod     = wave_ext * amp_ext;
    data_d   = prod[31:16];
  end

  logic unused_bits;
  assign unused_bits = ^{prod[32], prod[15:0], acc_q[7:0]};

  always_ff @(posedge i_clk50mhz) begin
    if (i_rst) begin
      acc_q  <= '0;
      wave_q <= '0;
      o_data <= '0;
    end else begin
      acc_q  <= acc_d;
      wave_q <= wave_d;
      o_data <= data_d;
    end
  end

endmodule

// File: tb/tb_synthy_boy.sv
`timescale 1ns / 1ps
// Bench for synthy_boy: a cycle model pushes the expected sample for every clock edge
// into a queue; a monitor pops and compares on the following falling edge. Directed
// checks with hand-computed values cover reset, latency and amplitude steps.
module tb_synthy_boy;

  localparam real Pi = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        amp;
  logic [1:0]         sel;
  logic signed [15:0] data;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #10 clk = ~clk;

  synthy_boy #(
    .PHASE_INC(336)
  ) dut (
    .i_clk50mhz(clk),
    .i_rst     (rst),
    .i_amp     (amp),
    .i_mux_sel (sel),
    .o_data    (data)
  );

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int shape(input longint acc, input logic [1:0] s);
    int  ph;
    int  q;
    int  k;
    int  v;
    real r;
    ph = int'(acc >> 8);
    case (s)
      2'd0:    return (ph < 32768) ? 32767 : -32768;
      2'd1:    return ph - 32768;
      2'd2:    return (ph < 32768) ? 2 * ph - 32768 : 2 * (65535 - ph) - 32768;
      default: begin
        q = ph / 16384;
        k = (ph / 64) % 256;
        if (q == 1 || q == 3) k = 255 - k;
        r = 32767.0 * $sin(Pi / 2.0 * (real'(k) + 0.5) / 256.0);
        v = $rtoi(r + 0.5);
        return (q >= 2) ? -v : v;
      end
    endcase
  endfunction

  // Reference model, advanced on each rising edge using the inputs the DUT samples.
  initial begin : model
    longint m_acc;
    int     m_wave;
    int     m_out;
    bit     m_live;
    m_acc = 0; m_wave = 0; m_out = 0; m_live = 0;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_acc = 0; m_wave = 0; m_out = 0; m_live = 1;
      end else begin
        m_out  = int'((longint'(m_wave) * longint'(amp)) >>> 16);
        m_wave = shape(m_acc, sel);
        m_acc  = (m_acc + 336) % (64'sd1 << 24);
      end
      if (m_live) exp_q.push_back(m_out);
    end
  end

  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream", data, e);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input int exp);
    @(negedge clk);
    check(name, data, exp);
  endtask

  task automatic restart(input logic [1:0] s);
    sel = s;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1;
    amp = 16'hFFFF;
    sel = 2'b00;
    repeat (3) tick();
    peek("reset_hold", 0);
    rst = 1'b0;

    // Square from reset: two zero samples, then the positive level.
    tick(); peek("sq_first", 0);
    tick(); peek("sq_second", 32766);
    repeat (24966) tick();
    peek("sq_pos_last", 32766);
    tick(); peek("sq_neg_first", -32768);

    // Amplitude steps on the negative level, each visible one clock later.
    amp = 16'h7FFF; tick(); peek("amp_neg_7fff", -16384);
    amp = 16'h3FFF; tick(); peek("amp_neg_3fff", -8192);
    amp = 16'h0000; tick(); peek("amp_neg_0000", 0);
    amp = 16'hFFFF; tick(); peek("amp_neg_ffff", -32768);

    // Amplitude steps on the positive level.
    restart(2'b00);
    peek("rst_pulse", 0);
    tick(); tick(); peek("sq_restart", 32766);
    amp = 16'h7FFF; tick(); peek("amp_pos_7fff", 16383);
    amp = 16'h3FFF; tick(); peek("amp_pos_3fff", 8191);
    amp = 16'h0000; tick(); peek("amp_pos_0000", 0);
    amp = 16'hFFFF;

    // Sawtooth and triangle from reset.
    restart(2'b01);
    tick(); peek("saw_first", 0);
    tick(); peek("saw_second", -32768);
    tick(); peek("saw_third", -32767);
    repeat (200) tick();

    restart(2'b10);
    tick(); tick(); peek("tri_second", -32768);
    tick(); peek("tri_third", -32766);
    repeat (200) tick();

    // Sine from reset through the positive peak and the mid-period zero crossing.
    restart(2'b11);
    tick(); peek("sin_first", 0);
    tick(); peek("sin_second", 100);
    repeat (25000) tick();

    // Mux cycling with a reset pulse in the middle of the triangle segment.
    restart(2'b00);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      if (s == 2) begin
        repeat (2500) tick();
        rst = 1'b1;
        tick(); peek("mid_rst_edge", 0);
        rst = 1'b0;
        tick(); peek("mid_rst_next", 0);
        tick(); peek("mid_rst_phase0", -32768);
        repeat (2497) tick();
      end else begin
        repeat (5000) tick();
      end
    end

    tick();
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/synthy_boy.md
# synthy_boy

Single-voice digital tone generator for the audio path. A phase accumulator clocked at 50 MHz drives one of four waveform shapers: square, sawtooth, triangle or sine. The selected waveform is scaled by a 16-bit amplitude word and emitted every clock as a signed 16-bit sample, ready for the downstream DAC/codec interface.

## Interface
- `PHASE_INC`, default 336: per-clock phase increment of the 24-bit accumulator; f_out = PHASE_INC × 50 MHz / 2^24, about 1.0014 kHz at the default.
- `i_clk50mhz`  in  1: 50 MHz system clock; all logic on its rising edge.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_amp`  in  16: unsigned amplitude; 0x0000 is silence, 0xFFFF is full scale.
- `i_mux_sel`  in  2: waveform select; 00 square, 01 sawtooth, 10 triangle, 11 sine.
- `o_data`  out  16: signed two's-complement sample, registered.

## Operation
- Accumulator `acc`, 24 bits, unsigned:
  - `acc <= acc + PHASE_INC` every clock.
  - Wraps modulo 2^24; no overflow flag.
- Phase `ph = acc[23:8]`, 16 bits. All four shapes are signed 16-bit values computed from `ph`.
- Square (00):
  - `ph[15]==0` gives +32767.
  - Otherwise −32768.
- Sawtooth (01):
  - `ph ^ 16'h8000`: a ramp from −32768 up to +32767.
  - Jumps back to −32768 at the wrap.
- Triangle (10):
  - `t = ph[15] ? ~ph[14:0] : ph[14:0]`, 15 bits.
  - Wave = `{t,1'b0} ^ 16'h8000`, range −32768..+32766.
  - Rises during the first half-period, falls during the second.
- Sine (11), quarter-wave ROM of 256 entries:
  - `lut[i] = round(32767·sin(π/2·(i+0.5)/256))`.
  - Quadrant `q = ph[15:14]`, index `k = ph[13:6]`.
  - q=0: `+lut[k]`; q=1: `+lut[255−k]`; q=2: `−lut[k]`; q=3: `−lut[255−k]`.
  - Endpoint values: lut[0]=101, lut[255]=32767.
- Waveform register `wave`:
  - Loaded each clock with the shape selected by the current `i_mux_sel`.
  - Switching shapes is immediate; no phase reset and no crossfade.
- Output scaling:
  - Form the 33-bit signed product `wave × {1'b0,i_amp}`.
  - `o_data <= product[31:16]`, i.e. an arithmetic shift right by 16 (floor).
  - Cannot overflow. `i_amp=0` gives 0; `i_amp=0xFFFF` gives `floor(wave·65535/65536)`.
- Reset (`i_rst` high at a clock edge): `acc`, `wave` and `o_data` all load 0.
  - Takes precedence over normal updates.
  - Holding reset keeps all three at 0.
  - Reset mid-waveform restarts from phase 0.

## Timing
- Three register stages: `acc` → `wave` → `o_data`.
- At edge n: `acc(n)=acc(n−1)+PHASE_INC`, `wave(n)=shape(acc(n−1), i_mux_sel sampled at n)`, `o_data(n)=wave(n−1)×i_amp sampled at n`.
- Latency:
  - `i_amp` change: 1 clock to `o_data`.
  - `i_mux_sel` change: 2 clocks to `o_data`.
  - Accumulator value: 2 clocks to `o_data`.
- After reset deasserts, the first edge loads `wave` with shape(phase 0); that sample appears on `o_data` at the second edge.
- The first two post-reset `o_data` samples are 0.
- No handshake; one new sample every clock, unconditionally.

## Test plan
- Reset, then square at `i_amp=0xFFFF`:
  - First two samples 0, then +32766.
  - Output goes to −32768 once `acc[23]` sets, about 24966 clocks later.
  - Full period about 49932 clocks.
- Sawtooth, amp 0xFFFF, from reset:
  - First non-zero sample −32768.
  - Monotonic rise to ≈+32766, then one-clock drop to −32768 at the accumulator wrap.
- Triangle:
  - Minimum −32768 at phase 0.
  - Peak ≈+32765 near `acc=0x800000`.
  - Symmetric descent; no sample outside −32768..+32766.
- Sine, amp 0xFFFF:
  - First sample after reset latency is 100.
  - Peak +32766 in quadrant 0/1, minimum −32767 in quadrant 2/3.
  - Zero crossings near `acc=0x800000` and wrap.
- Amplitude steps on square: `i_amp` 0xFFFF→0x7FFF→0x3FFF→0x0000 gives the positive level 32766→16383→8191→0 (negative level −32768→−16384→−8192→0), each visible 1 clock after the change.
- Mux cycling 00→01→10→11 every 5000 clocks:
  - Shape changes 2 clocks after each select edge.
  - `acc` keeps advancing by 336 per clock with no discontinuity.
  - A 1-clock `i_rst` pulse mid-run zeroes all outputs and restarts phase.
